// File: rtl/term_write_ctrl_if.sv
// Token stream in and display RAM write port out of the terminal write controller.
// Controller uses the slave modport; the token source / RAM side uses master.
interface term_write_ctrl_if;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_cmd;
   logic [7:0] in_char;
   logic       ram_we;
   logic [4:0] ram_row;
   logic [6:0] ram_col;
   logic [7:0] ram_wdata;

   modport master (
      output in_valid, in_cmd, in_char,
      input  in_ready, ram_we, ram_row, ram_col, ram_wdata
   );

   modport slave (
      input  in_valid, in_cmd, in_char,
      output in_ready, ram_we, ram_row, ram_col, ram_wdata
   );
endinterface

// File: rtl/term_write_ctrl.sv
// Cursor tracking and display RAM writes for the text terminal; token write 1 cycle after accept, in_ready low in WR and sweeps.
// SCROLL_EN: overflow clears one row and advances row_base instead of clearing the whole screen.
module term_write_ctrl #(
   parameter int ROWS = 30,
   parameter int COLS = 70
) (
   input  logic             clk,
   input  logic             clrn,
   term_write_ctrl_if.slave bus,
   output logic [4:0]       cur_row,
   output logic [6:0]       cur_col,
   output logic [4:0]       row_base,
   output logic             busy
);
   localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
   localparam logic [6:0] LAST_COL = 7'(COLS - 1);

   typedef enum logic [1:0] {SWEEP_ALL, IDLE, WR, SWEEP_ROW} state_t;

   state_t     state;
   state_t     after_wr;
   logic [4:0] sw_row;
   logic [6:0] sw_col;
   logic       sw_done;

   logic       tok_we;
   logic [4:0] tok_row;
   logic [6:0] tok_col;
   logic [7:0] tok_dat;
   logic [4:0] nxt_row;
   logic [6:0] nxt_col;
   logic       ovf;

   function automatic logic [4:0] phys(input logic [4:0] base, input logic [4:0] r);
      logic [5:0] s;
      s = {1'b0, base} + {1'b0, r};
      return (s >= 6'(ROWS)) ? 5'(s - 6'(ROWS)) : s[4:0];
   endfunction

   // Effect of the token currently offered, applied only on acceptance.
   always_comb begin
      tok_we  = 1'b0;
      tok_row = phys(row_base, cur_row);
      tok_col = cur_col;
      tok_dat = 8'd0;
      nxt_row = cur_row;
      nxt_col = cur_col;
      ovf     = 1'b0;
      case (bus.in_cmd)
         3'd0: begin
            tok_we  = 1'b1;
            tok_dat = bus.in_char;
            if (cur_col != LAST_COL) begin
               nxt_col = cur_col + 7'd1;
            end else if (cur_row != LAST_ROW) begin
               nxt_row = cur_row + 5'd1;
               nxt_col = 7'd0;
            end else begin
               ovf = 1'b1;
            end
         end
         3'd1: begin
            if (cur_row != LAST_ROW) begin
               nxt_row = cur_row + 5'd1;
               nxt_col = 7'd0;
            end else begin
               ovf = 1'b1;
            end
         end
         3'd2: begin
            tok_we = 1'b1;
            if (cur_col != 7'd0) begin
               nxt_col = cur_col - 7'd1;
               tok_col = cur_col - 7'd1;
            end else if (cur_row != 5'd0) begin
               nxt_row = cur_row - 5'd1;
               nxt_col = LAST_COL;
               tok_row = phys(row_base, cur_row - 5'd1);
               tok_col = LAST_COL;
            end
         end
         3'd3: begin
            nxt_row = 5'd0;
            nxt_col = 7'd0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clrn) begin
         state         <= SWEEP_ALL;
         after_wr      <= IDLE;
         sw_row        <= 5'd0;
         sw_col        <= 7'd0;
         sw_done       <= 1'b0;
         bus.in_ready  <= 1'b0;
         bus.ram_we    <= 1'b0;
         bus.ram_row   <= 5'd0;
         bus.ram_col   <= 7'd0;
         bus.ram_wdata <= 8'd0;
         cur_row       <= 5'd0;
         cur_col       <= 7'd0;
         row_base      <= 5'd0;
         busy          <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  state         <= WR;
                  bus.in_ready  <= 1'b0;
                  bus.ram_we    <= tok_we;
                  bus.ram_row   <= tok_row;
                  bus.ram_col   <= tok_col;
                  bus.ram_wdata <= tok_dat;
                  cur_row       <= nxt_row;
                  cur_col       <= nxt_col;
                  if (bus.in_cmd == 3'd3) begin
                     row_base <= 5'd0;
                     after_wr <= SWEEP_ALL;
                  end else if (ovf) begin
`ifdef SCROLL_EN
                     cur_row  <= LAST_ROW;
                     cur_col  <= 7'd0;
                     after_wr <= SWEEP_ROW;
`else
                     after_wr <= SWEEP_ALL;
`endif
                  end else begin
                     after_wr <= IDLE;
                  end
               end
            end
            // Leaving WR already issues the first sweep write so the sweep starts right after WR.
            WR: begin
               sw_done <= 1'b0;
               case (after_wr)
                  SWEEP_ALL: begin
                     state         <= SWEEP_ALL;
                     busy          <= 1'b1;
                     bus.ram_we    <= 1'b1;
                     bus.ram_row   <= 5'd0;
                     bus.ram_col   <= 7'd0;
                     bus.ram_wdata <= 8'd0;
                     sw_row        <= 5'd0;
                     sw_col        <= 7'd1;
                  end
                  SWEEP_ROW: begin
                     state         <= SWEEP_ROW;
                     busy          <= 1'b1;
                     bus.ram_we    <= 1'b1;
                     bus.ram_row   <= row_base;
                     bus.ram_col   <= 7'd0;
                     bus.ram_wdata <= 8'd0;
                     sw_col        <= 7'd1;
                  end
                  default: begin
                     state        <= IDLE;
                     bus.ram_we   <= 1'b0;
                     bus.in_ready <= 1'b1;
                  end
               endcase
            end
            SWEEP_ALL: begin
               if (sw_done) begin
                  state        <= IDLE;
                  bus.ram_we   <= 1'b0;
                  bus.in_ready <= 1'b1;
                  busy         <= 1'b0;
                  cur_row      <= 5'd0;
                  cur_col      <= 7'd0;
               end else begin
                  bus.ram_we    <= 1'b1;
                  bus.ram_row   <= sw_row;
                  bus.ram_col   <= sw_col;
                  bus.ram_wdata <= 8'd0;
                  if (sw_col == LAST_COL) begin
                     sw_col <= 7'd0;
                     if (sw_row == LAST_ROW) sw_done <= 1'b1;
                     else                    sw_row  <= sw_row + 5'd1;
                  end else begin
                     sw_col <= sw_col + 7'd1;
                  end
               end
            end
            SWEEP_ROW: begin
               if (sw_done) begin
                  state        <= IDLE;
                  bus.ram_we   <= 1'b0;
                  bus.in_ready <= 1'b1;
                  busy         <= 1'b0;
`ifdef SCROLL_EN
                  row_base     <= (row_base == LAST_ROW) ? 5'd0 : row_base + 5'd1;
`endif
               end else begin
                  bus.ram_we  <= 1'b1;
                  bus.ram_col <= sw_col;
                  if (sw_col == LAST_COL) sw_done <= 1'b1;
                  else                    sw_col  <= sw_col + 7'd1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_term_write_ctrl.sv
// Randomized token stream against a cursor/screen reference model; every RAM write is checked with its cycle offset.
module tb_term_write_ctrl;
   localparam int ROWS = 30;
   localparam int COLS = 70;
`ifdef SCROLL_EN
   localparam bit SCROLL = 1'b1;
`else
   localparam bit SCROLL = 1'b0;
`endif

   logic       clk  = 1'b0;
   logic       clrn = 1'b1;
   logic [4:0] cur_row;
   logic [6:0] cur_col;
   logic [4:0] row_base;
   logic       busy;

   term_write_ctrl_if bus();

   term_write_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
      .clk      (clk),
      .clrn     (clrn),
      .bus      (bus),
      .cur_row  (cur_row),
      .cur_col  (cur_col),
      .row_base (row_base),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int row;
      int col;
      int d;
   } wr_t;

   wr_t got_q[$];
   wr_t exp_q[$];
   int  cyc = 0;
   int  vectors = 0;
   int  miscompares = 0;
   int  mr, mc, mb;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk)
      if (!clrn && bus.ram_we)
         got_q.push_back(wr_t'{cyc, int'(bus.ram_row), int'(bus.ram_col), int'(bus.ram_wdata)});

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] pk(input int off, input int r, input int c, input int d);
      return (64'(off) << 24) | (64'(r) << 16) | (64'(c) << 8) | 64'(d);
   endfunction

   task automatic add_exp(input int off, input int r, input int c, input int d);
      exp_q.push_back(wr_t'{off, r, c, d});
   endtask

   task automatic sweep_all(output int rdy);
      for (int i = 0; i < ROWS * COLS; i++) add_exp(2 + i, i / COLS, i % COLS, 0);
      rdy = 2 + ROWS * COLS;
   endtask

   // Reference: expected writes as (cycle offset from acceptance, row, col, data).
   task automatic model_token(input int cmd, input int ch, output int rdy, output bit ovf);
      ovf = 1'b0;
      rdy = 2;
      case (cmd)
         0: begin
            add_exp(1, (mb + mr) % ROWS, mc, ch);
            if (mc < COLS - 1) mc++;
            else if (mr < ROWS - 1) begin mr++; mc = 0; end
            else ovf = 1'b1;
         end
         1: begin
            if (mr < ROWS - 1) begin mr++; mc = 0; end
            else ovf = 1'b1;
         end
         2: begin
            if (mc > 0) mc--;
            else if (mr > 0) begin mr--; mc = COLS - 1; end
            add_exp(1, (mb + mr) % ROWS, mc, 0);
         end
         3: begin
            mr = 0; mc = 0; mb = 0;
            sweep_all(rdy);
         end
         default: ;
      endcase
      if (ovf) begin
`ifdef SCROLL_EN
         mr = ROWS - 1;
         mc = 0;
         for (int c = 0; c < COLS; c++) add_exp(2 + c, mb, c, 0);
         rdy = 2 + COLS;
         mb = (mb + 1) % ROWS;
`else
         sweep_all(rdy);
         mr = 0;
         mc = 0;
`endif
      end
   endtask

   task automatic send_token(input logic [2:0] cmd, input logic [7:0] ch);
      int acc, n, exp_rdy, base0;
      bit ovf;
      n = 0;
      while (!bus.in_ready && n < 3000) begin @(negedge clk); n++; end
      if (!bus.in_ready) begin
         check("ready_timeout", 64'd0, 64'd1);
         return;
      end
      got_q.delete();
      exp_q.delete();
      base0 = mb;
      model_token(int'(cmd), int'(ch), exp_rdy, ovf);
      bus.in_valid = 1'b1;
      bus.in_cmd   = cmd;
      bus.in_char  = ch;
      acc = cyc;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_cmd   = 3'($urandom);
      bus.in_char  = 8'($urandom);
      check("we_t1", 64'(bus.ram_we), 64'(cmd == 3'd0 || cmd == 3'd2));
      check("ready_t1", 64'(bus.in_ready), 64'd0);
      if (!ovf || SCROLL) check("cursor_t1", {cur_row, cur_col}, {5'(mr), 7'(mc)});
      check("base_t1", 64'(row_base), 64'((cmd == 3'd3) ? 0 : base0));
      n = 0;
      while (!bus.in_ready && n < ROWS * COLS + 10) begin @(negedge clk); n++; end
      check("ready_latency", 64'(cyc - acc), 64'(exp_rdy));
      check("n_writes", 64'(got_q.size()), 64'(exp_q.size()));
      foreach (exp_q[i])
         if (i < got_q.size())
            check("write", pk(got_q[i].cyc - acc, got_q[i].row, got_q[i].col, got_q[i].d),
                  pk(exp_q[i].cyc, exp_q[i].row, exp_q[i].col, exp_q[i].d));
      check("idle_state", {cur_row, cur_col, row_base, busy}, {5'(mr), 7'(mc), 5'(mb), 1'b0});
   endtask

   task automatic reset_and_sweep(input int abort_at);
      clrn = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_values",
            {bus.in_ready, bus.ram_we, bus.ram_row, bus.ram_col, bus.ram_wdata, cur_row, cur_col, row_base, busy},
            {1'b0, 1'b0, 5'd0, 7'd0, 8'd0, 5'd0, 7'd0, 5'd0, 1'b1});
      mr = 0; mc = 0; mb = 0;
      clrn = 1'b0;
      for (int k = 1; k <= ROWS * COLS; k++) begin
         @(negedge clk);
         check("init_sweep", {bus.ram_we, bus.in_ready, busy, bus.ram_row, bus.ram_col, bus.ram_wdata},
               {1'b1, 1'b0, 1'b1, 5'((k - 1) / COLS), 7'((k - 1) % COLS), 8'd0});
         if (k == abort_at) begin
            clrn = 1'b1;
            @(negedge clk);
            check("abort", {bus.ram_we, bus.in_ready, busy}, {1'b0, 1'b0, 1'b1});
            return;
         end
      end
      @(negedge clk);
      check("sweep_done", {bus.in_ready, busy, bus.ram_we, cur_row, cur_col, row_base},
            {1'b1, 1'b0, 1'b0, 5'd0, 7'd0, 5'd0});
   endtask

   initial begin
      int r;
      bus.in_valid = 1'b0;
      bus.in_cmd   = 3'd0;
      bus.in_char  = 8'd0;

      reset_and_sweep(0);

      send_token(3'd0, 8'h41);
      send_token(3'd0, 8'h42);
      check("ab_cursor", {cur_row, cur_col}, {5'd0, 7'd2});

      send_token(3'd3, 8'h00);
      send_token(3'd2, 8'h00);
      check("bs_origin", {cur_row, cur_col}, {5'd0, 7'd0});
      repeat (3) send_token(3'd1, 8'h00);
      send_token(3'd2, 8'h00);
      check("bs_wrap", {cur_row, cur_col}, {5'd2, 7'd69});

      // Fill the last row until overflow; with scrolling, repeat until row_base wraps.
      send_token(3'd3, 8'h00);
      repeat (ROWS - 1) send_token(3'd1, 8'h00);
      for (int k = 0; k < (SCROLL ? ROWS : 1); k++)
         repeat (COLS) send_token(3'd0, 8'($urandom_range(33, 126)));
      check("overflow_end", {cur_row, cur_col, row_base},
            {(SCROLL ? 5'd29 : 5'd0), 7'd0, 5'd0});

      for (int t = 0; t < 300; t++) begin
         r = $urandom_range(0, 99);
         if (r < 55)      send_token(3'd0, 8'($urandom));
         else if (r < 80) send_token(3'd1, 8'($urandom));
         else if (r < 93) send_token(3'd2, 8'($urandom));
         else if (r < 95) send_token(3'd3, 8'($urandom));
         else             send_token(3'($urandom_range(4, 7)), 8'($urandom));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      reset_and_sweep(500);
      reset_and_sweep(0);
      send_token(3'd0, 8'h5a);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
